// File: rtl/event_encoder_8.sv
// event_encoder_8: captures eight request lines into a pending set and hands them out lowest-index-first over Valid/Ack.
// Define EVENT_ENCODER_EDGE_EN for rising-edge capture; level capture otherwise.
module event_encoder_8 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       EncoderIn_0,
  input  logic       EncoderIn_1,
  input  logic       EncoderIn_2,
  input  logic       EncoderIn_3,
  input  logic       EncoderIn_4,
  input  logic       EncoderIn_5,
  input  logic       EncoderIn_6,
  input  logic       EncoderIn_7,
  input  logic       Ack,
  output logic [2:0] Sel,
  output logic       Valid,
  output logic       Overflow
);
  typedef enum logic {S_IDLE, S_PRESENT} state_t;
  state_t     r_state, w_next;
  logic [7:0] w_in, w_event, w_cap, w_clr, r_pending;
  logic [2:0] w_pick;
  logic       w_load;
  assign w_in = {EncoderIn_7, EncoderIn_6, EncoderIn_5, EncoderIn_4,
                 EncoderIn_3, EncoderIn_2, EncoderIn_1, EncoderIn_0};
`ifdef EVENT_ENCODER_EDGE_EN
  logic [7:0] r_in_prev;
  // Held high through reset so a line already asserted yields no event.
  always_ff @(posedge Clock) r_in_prev <= Reset ? 8'hFF : w_in;
  assign w_event = w_in & ~r_in_prev;
`else
  assign w_event = w_in;
`endif
  assign w_cap = {8{Enable}} & w_event;
  always_comb begin
    w_pick = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (r_pending[i]) w_pick = 3'(i);
  end
  always_comb begin
    w_load = |r_pending && (r_state == S_IDLE || Ack);
    w_next = (w_load || (r_state == S_PRESENT && !Ack)) ? S_PRESENT : S_IDLE;
    w_clr  = w_load ? 8'd1 << w_pick : 8'd0;
  end
  assign Valid = r_state == S_PRESENT;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pending <= 8'd0;
      Sel       <= 3'd0;
      Overflow  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pending <= (r_pending & ~w_clr) | w_cap;
      if (w_load) Sel <= w_pick;
      if (|(w_cap & r_pending & ~w_clr)) Overflow <= 1'b1;
    end
  end
endmodule
